// File: rtl/cmd_scheduler_rr.sv
// Round-robin command scheduler: arbitrates NCHAN requesters onto one command stream,
// limits in-flight commands to MAX_OUT credits and routes in-order completions back.
module cmd_scheduler_rr #(
  parameter int unsigned NCHAN   = 4,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned MAX_OUT = 8,
  localparam int unsigned CW = (NCHAN > 1) ? $clog2(NCHAN) : 1,
  localparam int unsigned PW = $clog2(MAX_OUT),
  localparam int unsigned OW = PW + 1
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst,
  input  logic [NCHAN-1:0]        req_valid,
  output logic [NCHAN-1:0]        req_ready,
  input  logic [NCHAN*ADDR_W-1:0] req_addr,
  input  logic [NCHAN-1:0]        req_we,
  output logic                    cmd_valid,
  input  logic                    cmd_ready,
  output logic [ADDR_W-1:0]       cmd_addr,
  output logic                    cmd_we,
  output logic [CW-1:0]           cmd_chan,
  input  logic                    cmd_executed,
  output logic [NCHAN-1:0]        done,
  output logic [OW-1:0]           outstanding,
  output logic                    idle,
  output logic                    err
);

  typedef enum logic {StIdle, StIssue} state_e;

  state_e             state_q;
  logic [CW-1:0]      last_grant_q;
  logic [ADDR_W-1:0]  cmd_addr_q;
  logic               cmd_we_q;
  logic [CW-1:0]      cmd_chan_q;
  logic [OW-1:0]      outstanding_q;
  logic [NCHAN-1:0]   done_q;
  logic               err_q;

  logic [CW-1:0]      tag_mem [MAX_OUT];
  logic [PW-1:0]      wr_ptr_q;
  logic [PW-1:0]      rd_ptr_q;
  logic [OW-1:0]      fifo_cnt_q;

  logic [CW-1:0]      grant;
  logic               found;
  logic [ADDR_W-1:0]  sel_addr;
  logic               sel_we;
  logic               release_c;
  logic               credit_ok;
  logic               capture;
  logic               handshake;

  assign cmd_valid   = (state_q == StIssue);
  assign cmd_addr    = cmd_addr_q;
  assign cmd_we      = cmd_we_q;
  assign cmd_chan    = cmd_chan_q;
  assign outstanding = outstanding_q;
  assign done        = done_q;
  assign err         = err_q;
  assign idle        = !cmd_valid && (outstanding_q == '0);

  // Rotating priority: search upward from the channel after the last grant.
  always_comb begin
    int idx;
    grant = last_grant_q;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= int'(NCHAN); k++) begin
      idx = (int'(last_grant_q) + k) % int'(NCHAN);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        grant = CW'(idx);
      end
    end
  end

  always_comb begin
    sel_addr = '0;
    sel_we   = 1'b0;
    for (int i = 0; i < int'(NCHAN); i++) begin
      if (CW'(i) == grant) begin
        sel_addr = req_addr[i*ADDR_W +: ADDR_W];
        sel_we   = req_we[i];
      end
    end
  end

  assign release_c = cmd_executed && (fifo_cnt_q != '0);
  // A same-cycle completion frees a credit for this capture.
  assign credit_ok = (outstanding_q < OW'(MAX_OUT)) || release_c;
  assign capture   = ((state_q == StIdle) || cmd_ready) && found && credit_ok;
  assign handshake = cmd_valid && cmd_ready;

  always_comb begin
    req_ready = '0;
    if (capture) req_ready = NCHAN'(1) << grant;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q       <= StIdle;
      last_grant_q  <= CW'(NCHAN - 1);
      cmd_addr_q    <= '0;
      cmd_we_q      <= 1'b0;
      cmd_chan_q    <= '0;
      outstanding_q <= '0;
      done_q        <= '0;
      err_q         <= 1'b0;
    end else begin
      if (capture) begin
        state_q      <= StIssue;
        last_grant_q <= grant;
        cmd_addr_q   <= sel_addr;
        cmd_we_q     <= sel_we;
        cmd_chan_q   <= grant;
      end else if (state_q == StIssue && cmd_ready) begin
        state_q <= StIdle;
      end

      case ({capture, release_c})
        2'b10:   outstanding_q <= outstanding_q + OW'(1);
        2'b01:   outstanding_q <= outstanding_q - OW'(1);
        default: outstanding_q <= outstanding_q;
      endcase

      done_q <= release_c ? (NCHAN'(1) << tag_mem[rd_ptr_q]) : '0;
      if (cmd_executed && (fifo_cnt_q == '0)) err_q <= 1'b1;
    end
  end

  // Tag FIFO: issuing channel of each accepted command, popped by in-order completions.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (handshake) begin
        tag_mem[wr_ptr_q] <= cmd_chan_q;
        wr_ptr_q          <= wr_ptr_q + PW'(1);
      end
      if (release_c) rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({handshake, release_c})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + OW'(1);
        2'b01:   fifo_cnt_q <= fifo_cnt_q - OW'(1);
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_scheduler_rr.sv
// Directed bench for cmd_scheduler_rr with 4 channels and 8 credits.
module tb_cmd_scheduler_rr;
  localparam int NCHAN = 4;
  localparam int ADDR_W = 32;

  logic                    sys_clk = 1'b0;
  logic                    sys_rst;
  logic [NCHAN-1:0]        req_valid;
  logic [NCHAN-1:0]        req_ready;
  logic [NCHAN*ADDR_W-1:0] req_addr;
  logic [NCHAN-1:0]        req_we;
  logic                    cmd_valid;
  logic                    cmd_ready;
  logic [ADDR_W-1:0]       cmd_addr;
  logic                    cmd_we;
  logic [1:0]              cmd_chan;
  logic                    cmd_executed;
  logic [NCHAN-1:0]        done;
  logic [3:0]              outstanding;
  logic                    idle;
  logic                    err;

  int checks = 0;
  int errors = 0;
  int ncap;

  cmd_scheduler_rr #(.NCHAN(4), .ADDR_W(32), .MAX_OUT(8)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_we(req_we),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_we(cmd_we),
    .cmd_chan(cmd_chan), .cmd_executed(cmd_executed), .done(done),
    .outstanding(outstanding), .idle(idle), .err(err)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] oh(input int i);
    logic [3:0] v;
    v = 4'b0001 << i;
    return v;
  endfunction

  initial begin
    sys_rst = 1'b1; req_valid = '0; req_we = '0; cmd_ready = 1'b0; cmd_executed = 1'b0;
    for (int i = 0; i < NCHAN; i++) req_addr[i*ADDR_W +: ADDR_W] = 32'hA000_0000 + i;
    repeat (2) @(negedge sys_clk);
    #1;
    chk("rst_valid", cmd_valid, 0);     chk("rst_addr", cmd_addr, 0);
    chk("rst_we", cmd_we, 0);           chk("rst_chan", cmd_chan, 0);
    chk("rst_ready", req_ready, 0);     chk("rst_done", done, 0);
    chk("rst_out", outstanding, 0);     chk("rst_idle", idle, 1);
    chk("rst_err", err, 0);

    // All channels requesting; completions two cycles after each handshake.
    for (int k = 0; k < 12; k++) begin
      @(negedge sys_clk);
      sys_rst = 1'b0; cmd_ready = 1'b1;
      req_valid = (k < 8) ? 4'hF : 4'h0;
      cmd_executed = (k >= 3 && k <= 10);
      #1;
      chk("rr_ready", req_ready, (k < 8) ? oh(k % 4) : 4'b0);
      if (k >= 1 && k <= 8) begin
        chk("rr_valid", cmd_valid, 1);
        chk("rr_chan", cmd_chan, (k - 1) % 4);
        chk("rr_addr", cmd_addr, 32'hA000_0000 + ((k - 1) % 4));
      end
      chk("rr_done", done, (k >= 4) ? oh((k - 4) % 4) : 4'b0);
    end
    @(negedge sys_clk);
    req_valid = '0; cmd_executed = 1'b0;
    #1;
    chk("rr_end_out", outstanding, 0); chk("rr_end_idle", idle, 1);
    chk("rr_end_valid", cmd_valid, 0); chk("rr_end_done", done, 0);

    // Single channel, no completions: credit limit stops at 8.
    ncap = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge sys_clk);
      req_valid = 4'b0100;
      #1;
      if (req_ready[2]) ncap++;
      chk("cr_other_ready", req_ready & 4'b1011, 0);
    end
    chk("cr_caps", ncap, 8);
    chk("cr_out", outstanding, 8);
    chk("cr_valid", cmd_valid, 0);
    chk("cr_blocked", req_ready, 0);
    @(negedge sys_clk);
    cmd_executed = 1'b1;
    #1;
    chk("cr_exec_cap", req_ready, 4'b0100);
    @(negedge sys_clk);
    cmd_executed = 1'b0; req_valid = '0;
    #1;
    chk("cr_done", done, 4'b0100);
    chk("cr_out_same", outstanding, 8);
    chk("cr_chan", cmd_chan, 2);
    for (int i = 0; i < 8; i++) begin
      @(negedge sys_clk);
      cmd_executed = 1'b1;
      #1;
      chk("drain_done", done, (i == 0) ? 4'b0 : 4'b0100);
    end
    @(negedge sys_clk);
    cmd_executed = 1'b0;
    #1;
    chk("drain_done_last", done, 4'b0100);
    chk("drain_out", outstanding, 0);
    chk("drain_idle", idle, 1);
    chk("drain_err", err, 0);

    // Backpressure: held command stays stable, no grants while stalled.
    @(negedge sys_clk);
    req_addr[1*ADDR_W +: ADDR_W] = 32'h0000_1000; req_we = 4'b0010;
    req_valid = 4'b0010; cmd_ready = 1'b0;
    #1;
    chk("bp_cap", req_ready, 4'b0010);
    for (int i = 0; i < 5; i++) begin
      @(negedge sys_clk);
      req_valid = 4'b1000;
      #1;
      chk("bp_valid", cmd_valid, 1);   chk("bp_addr", cmd_addr, 32'h1000);
      chk("bp_we", cmd_we, 1);         chk("bp_chan", cmd_chan, 1);
      chk("bp_ready", req_ready, 0);
    end
    @(negedge sys_clk);
    cmd_ready = 1'b1;
    #1;
    chk("bp_next_cap", req_ready, 4'b1000);
    @(negedge sys_clk);
    req_valid = '0;
    #1;
    chk("bp_next_chan", cmd_chan, 3);
    chk("bp_next_addr", cmd_addr, 32'hA000_0003);
    chk("bp_next_we", cmd_we, 0);

    // Completion with nothing issued sets sticky err.
    @(negedge sys_clk);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    sys_rst = 1'b0; cmd_executed = 1'b1;
    #1;
    chk("er_out0", outstanding, 0);
    @(negedge sys_clk);
    cmd_executed = 1'b0;
    #1;
    chk("er_err", err, 1); chk("er_done", done, 0); chk("er_out", outstanding, 0);
    @(negedge sys_clk);
    #1;
    chk("er_sticky", err, 1);

    // Reset with 3 completed handshakes pending and one command held.
    @(negedge sys_clk);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    sys_rst = 1'b0; req_valid = 4'b0111; cmd_ready = 1'b1;
    #1;
    chk("mr_g0", req_ready, 4'b0001);
    @(negedge sys_clk);
    #1;
    chk("mr_g1", req_ready, 4'b0010);
    @(negedge sys_clk);
    #1;
    chk("mr_g2", req_ready, 4'b0100);
    @(negedge sys_clk);
    req_valid = 4'b0001;
    #1;
    chk("mr_g3", req_ready, 4'b0001);
    @(negedge sys_clk);
    req_valid = '0; cmd_ready = 1'b0; sys_rst = 1'b1;
    #1;
    chk("mr_out4", outstanding, 4); chk("mr_held", cmd_valid, 1);
    chk("mr_err0", err, 0);
    @(negedge sys_clk);
    sys_rst = 1'b0; cmd_executed = 1'b1;
    #1;
    chk("mr_valid", cmd_valid, 0); chk("mr_out", outstanding, 0); chk("mr_idle", idle, 1);
    @(negedge sys_clk);
    #1;
    chk("mr_err", err, 1); chk("mr_done_a", done, 0);
    @(negedge sys_clk);
    cmd_executed = 1'b0;
    #1;
    chk("mr_done_b", done, 0); chk("mr_out_b", outstanding, 0);
    @(negedge sys_clk);
    #1;
    chk("mr_done_c", done, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
